count_monitor: RTL and testbench



---
 rtl/count_monitor_if.sv | 29 ++
 rtl/count_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_count_monitor.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_monitor_if.sv
// -----------------------------------------------------------------------------
// count_monitor_if
//
// Carries the pair of free-running count buses from the ALU to the monitor.
// The ALU drives both buses through the master modport. The checker reads
// them through the slave modport.
//
// Signals:
//   count_a  WIDTH  first counter value (alucount)
//   count_b  WIDTH  second counter value (alucount2)
// -----------------------------------------------------------------------------
interface count_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] count_a;
  logic [WIDTH-1:0] count_b;

  modport master (
    output count_a,
    output count_b
  );

  modport slave (
    input count_a,
    input count_b
  );

endinterface : count_if

// File: rtl/count_monitor.sv
// -----------------------------------------------------------------------------
// count_monitor
//
// Checks the pair of free-running up-counters in the ALU. Every clock the
// monitor samples both count buses and tests two things:
//   - each bus has stepped by exactly +1, modulo 2^WIDTH
//   - the two buses are equal
// After LOCK_CYCLES consecutive good comparisons the monitor locks onto the
// streams. The first bad comparison while locked pulses the matching error
// flags, counts one error event and parks the monitor in FAULT until
// software clears the error.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   enable        in   monitor enable; low forces IDLE on the next edge
//   bus           in   count_if.slave, carries count_a / count_b
//   clear_err     in   clears err_sticky and err_count; leaves FAULT
//   locked        out  high while the monitor is in LOCKED
//   err_step_a    out  one-cycle pulse: count_a did not step by +1
//   err_step_b    out  one-cycle pulse: count_b did not step by +1
//   err_mismatch  out  one-cycle pulse: count_a != count_b
//   err_sticky    out  set by any error while locked, cleared by clear_err
//   err_count     out  number of error events, saturates at 255
//   wrap_count    out  count_a wraps seen while locked, modulo 256
//
// Every output is a register.
// -----------------------------------------------------------------------------
module count_monitor #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 2   // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  count_if.slave      bus,
  input  logic        clear_err,
  output logic        locked,
  output logic        err_step_a,
  output logic        err_step_b,
  output logic        err_mismatch,
  output logic        err_sticky,
  output logic [7:0]  err_count,
  output logic [7:0]  wrap_count
);

  // ---------------------------------------------------------------------------
  // Constants and state
  // ---------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev_a;
  logic [WIDTH-1:0] prev_b;
  logic [3:0]       good_cnt;

  // ---------------------------------------------------------------------------
  // Comparisons against the previous sample
  // ---------------------------------------------------------------------------
  // The +1 is kept at WIDTH bits, so the step 2^WIDTH-1 -> 0 counts as a good
  // step and not as an error.
  logic [WIDTH-1:0] exp_a;
  logic [WIDTH-1:0] exp_b;
  logic             step_ok_a;
  logic             step_ok_b;
  logic             eq_ok;
  logic             all_ok;
  logic             wrap_seen;
  logic [3:0]       good_inc;
  logic [7:0]       err_inc;

  assign exp_a     = prev_a + ONE;
  assign exp_b     = prev_b + ONE;
  assign step_ok_a = (bus.count_a == exp_a);
  assign step_ok_b = (bus.count_b == exp_b);
  assign eq_ok     = (bus.count_a == bus.count_b);
  assign all_ok    = step_ok_a & step_ok_b & eq_ok;

  // A wrap is a good step of count_a that lands on zero.
  assign wrap_seen = step_ok_a && (bus.count_a == '0);

  assign good_inc  = good_cnt + 4'd1;

  // The error counter saturates, so a long-running self-test never reads back
  // a small number after many faults.
  assign err_inc   = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

  // ---------------------------------------------------------------------------
  // Monitor state machine and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register in this block uses non-blocking assignments. All
  // right-hand sides therefore see the values from before the edge. When a
  // register is assigned more than once in one pass, the last assignment wins.
  // The clear-then-count ordering of err_count and err_sticky below depends on
  // that rule.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the sample history is reset together with the control state.
      // This makes the first comparison after reset well defined (against 0)
      // and not dependent on X.
      state        <= IDLE;
      prev_a       <= '0;
      prev_b       <= '0;
      good_cnt     <= 4'd0;
      locked       <= 1'b0;
      err_step_a   <= 1'b0;
      err_step_b   <= 1'b0;
      err_mismatch <= 1'b0;
      err_sticky   <= 1'b0;
      err_count    <= 8'd0;
      wrap_count   <= 8'd0;
    end else begin
      // The history loads in every state, so any state starts comparing
      // against a fresh sample.
      prev_a       <= bus.count_a;
      prev_b       <= bus.count_b;

      // The error flags are pulses. By default they are low.
      err_step_a   <= 1'b0;
      err_step_b   <= 1'b0;
      err_mismatch <= 1'b0;

      // A clear takes effect first. An error counted later in this same pass
      // overrides it, which leaves err_count = 1 and err_sticky = 1.
      if (clear_err) begin
        err_sticky <= 1'b0;
        err_count  <= 8'd0;
      end

      if (!enable) begin
        // Disable wins over every other transition. The error history and the
        // wrap history are kept for software to read.
        state    <= IDLE;
        good_cnt <= 4'd0;
        locked   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state    <= ACQUIRE;
            good_cnt <= 4'd0;
            locked   <= 1'b0;
          end

          ACQUIRE: begin
            // Errors are silent here. The streams are not trusted yet.
            if (all_ok) begin
              if (good_inc == LOCK_TGT) begin
                state    <= LOCKED;
                good_cnt <= 4'd0;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_inc;
              end
            end else begin
              good_cnt <= 4'd0;
            end
          end

          LOCKED: begin
            if (wrap_seen) begin
              wrap_count <= wrap_count + 8'd1;
            end
            if (!all_ok) begin
              err_step_a   <= !step_ok_a;
              err_step_b   <= !step_ok_b;
              err_mismatch <= !eq_ok;
              err_sticky   <= 1'b1;
              // One event counts once, however many flags fire. A clear on
              // the same edge makes this the first event.
              err_count    <= clear_err ? 8'd1 : err_inc;
              state        <= FAULT;
              locked       <= 1'b0;
            end
          end

          FAULT: begin
            // Stay here until software acknowledges the fault. Then start
            // acquiring again from zero.
            locked <= 1'b0;
            if (clear_err) begin
              state    <= ACQUIRE;
              good_cnt <= 4'd0;
            end
          end

          default: begin
            state    <= IDLE;
            good_cnt <= 4'd0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : count_monitor

// File: tb/tb_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_monitor
//
// Directed bring-up sequence followed by a randomized soak for count_monitor.
// A behavioural reference model computes every expected output from the
// monitor's rules. Key points of the directed sequence are also checked
// against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_count_monitor;

  localparam int W    = 8;
  localparam int LOCK = 2;
  localparam int MOD  = 1 << W;

  // Reference-model phases
  localparam int P_IDLE   = 0;
  localparam int P_ACQ    = 1;
  localparam int P_LOCKED = 2;
  localparam int P_FAULT  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear_err;
  logic       locked;
  logic       err_step_a;
  logic       err_step_b;
  logic       err_mismatch;
  logic       err_sticky;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  count_if #(.WIDTH(W)) cif ();

  count_monitor #(
    .WIDTH       (W),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bus          (cif),
    .clear_err    (clear_err),
    .locked       (locked),
    .err_step_a   (err_step_a),
    .err_step_b   (err_step_b),
    .err_mismatch (err_mismatch),
    .err_sticky   (err_sticky),
    .err_count    (err_count),
    .wrap_count   (wrap_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_phase, m_streak, m_pa, m_pb, m_wrap, m_errcnt;
  bit m_locked, m_sa, m_sb, m_mm, m_sticky;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_streak = 0;
    m_pa     = 0;
    m_pb     = 0;
    m_wrap   = 0;
    m_errcnt = 0;
    m_locked = 0;
    m_sa     = 0;
    m_sb     = 0;
    m_mm     = 0;
    m_sticky = 0;
  endtask

  // Applies the monitor rules to the inputs present at one rising edge.
  task automatic model_edge();
    int a, b;
    bit sa, sb, eq, ok;
    a = int'(cif.count_a);
    b = int'(cif.count_b);
    if (reset) begin
      model_reset();
      return;
    end
    sa = (a == (m_pa + 1) % MOD);
    sb = (b == (m_pb + 1) % MOD);
    eq = (a == b);
    ok = sa && sb && eq;
    m_sa = 0;
    m_sb = 0;
    m_mm = 0;
    if (clear_err) begin
      m_errcnt = 0;
      m_sticky = 0;
    end
    if (!enable) begin
      m_phase  = P_IDLE;
      m_streak = 0;
    end else if (m_phase == P_IDLE) begin
      m_phase  = P_ACQ;
      m_streak = 0;
    end else if (m_phase == P_ACQ) begin
      m_streak = ok ? m_streak + 1 : 0;
      if (m_streak == LOCK) m_phase = P_LOCKED;
    end else if (m_phase == P_LOCKED) begin
      if (a == 0 && sa) m_wrap = (m_wrap + 1) % 256;
      if (!ok) begin
        m_sa     = !sa;
        m_sb     = !sb;
        m_mm     = !eq;
        m_sticky = 1;
        m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
        m_phase  = P_FAULT;
      end
    end else begin
      if (clear_err) begin
        m_phase  = P_ACQ;
        m_streak = 0;
      end
    end
    m_locked = (m_phase == P_LOCKED);
    m_pa = a;
    m_pb = b;
  endtask

  task automatic compare_model();
    check("locked",       locked,       m_locked);
    check("err_step_a",   err_step_a,   m_sa);
    check("err_step_b",   err_step_b,   m_sb);
    check("err_mismatch", err_mismatch, m_mm);
    check("err_sticky",   err_sticky,   m_sticky);
    check("err_count",    err_count,    m_errcnt);
    check("wrap_count",   wrap_count,   m_wrap);
  endtask

  // One clock: the model sees the same inputs as the DUT. The outputs are
  // then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drive(input int a, input int b);
    cif.count_a = a[W-1:0];
    cif.count_b = b[W-1:0];
  endtask

  task automatic flags_quiet(input string tag);
    check({tag, "_step_a"},   err_step_a,   1'b0);
    check({tag, "_step_b"},   err_step_b,   1'b0);
    check({tag, "_mismatch"}, err_mismatch, 1'b0);
  endtask

  initial begin
    int v, a, b, r;
    model_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    clear_err = 1'b0;
    drive(0, 0);

    // Reset state
    tick();
    tick();
    check("rst_locked", locked, 1'b0);
    check("rst_errcnt", err_count, 8'd0);
    check("rst_wrap",   wrap_count, 8'd0);
    check("rst_sticky", err_sticky, 1'b0);

    // Lock on clean streams 0,1,2,...: locked rises after E0+2
    reset  = 1'b0;
    enable = 1'b1;
    drive(0, 0); tick();                  // E0
    drive(1, 1); tick();
    check("lock_early", locked, 1'b0);
    drive(2, 2); tick();
    check("lock_rise",   locked, 1'b1);
    check("lock_errcnt", err_count, 8'd0);
    flags_quiet("lock");
    for (int i = 3; i <= 11; i++) begin
      drive(i, i); tick();
    end

    // count_b skips: 11 -> 13 while count_a goes 11 -> 12
    drive(12, 13); tick();
    check("skip_step_a",   err_step_a, 1'b0);
    check("skip_step_b",   err_step_b, 1'b1);
    check("skip_mismatch", err_mismatch, 1'b1);
    check("skip_errcnt",   err_count, 8'd1);
    check("skip_sticky",   err_sticky, 1'b1);
    check("skip_locked",   locked, 1'b0);
    drive(13, 14); tick();
    flags_quiet("pulse_end");
    drive(99, 7); tick();
    drive(3, 3);  tick();
    check("fault_errcnt_hold", err_count, 8'd1);

    // Clear in FAULT, then relock after two good edges
    clear_err = 1'b1;
    drive(50, 50); tick();
    clear_err = 1'b0;
    check("clr_errcnt", err_count, 8'd0);
    check("clr_sticky", err_sticky, 1'b0);
    drive(51, 51); tick();
    check("relock_early", locked, 1'b0);
    drive(52, 52); tick();
    check("relock", locked, 1'b1);

    // Run through 254, 255, 0, 1
    for (int i = 53; i <= 255; i++) begin
      drive(i, i); tick();
    end
    check("prewrap", wrap_count, 8'd0);
    drive(0, 0); tick();
    drive(1, 1); tick();
    check("wrap_count", wrap_count, 8'd1);
    check("wrap_errcnt", err_count, 8'd0);
    check("wrap_locked", locked, 1'b1);
    flags_quiet("wrap");

    // Error, then relock with err_count retained through IDLE
    drive(2, 5); tick();
    enable = 1'b0;
    drive(6, 6); tick();
    enable = 1'b1;
    drive(7, 7); tick();
    drive(8, 8); tick();
    drive(9, 9); tick();
    check("relock2", locked, 1'b1);
    check("relock2_errcnt", err_count, 8'd1);

    // Stall with clear_err on the same edge: the clear applies first
    clear_err = 1'b1;
    drive(9, 9); tick();
    clear_err = 1'b0;
    check("clrerr_errcnt",   err_count, 8'd1);
    check("clrerr_sticky",   err_sticky, 1'b1);
    check("stall_step_a",    err_step_a, 1'b1);
    check("stall_step_b",    err_step_b, 1'b1);
    check("stall_mismatch",  err_mismatch, 1'b0);
    check("clrerr_locked",   locked, 1'b0);

    // Drop enable while locked, then reset mid-stream
    enable = 1'b0;
    drive(19, 19); tick();
    enable = 1'b1;
    drive(20, 20); tick();
    drive(21, 21); tick();
    drive(22, 22); tick();
    check("relock3", locked, 1'b1);
    enable = 1'b0;
    drive(23, 23); tick();
    check("dis_locked", locked, 1'b0);
    check("dis_errcnt", err_count, 8'd1);
    check("dis_wrap",   wrap_count, 8'd1);
    enable = 1'b1;
    drive(24, 24); tick();
    drive(25, 25); tick();
    drive(26, 26); tick();
    reset = 1'b1;
    drive(27, 27); tick();
    check("mid_rst_locked", locked, 1'b0);
    check("mid_rst_errcnt", err_count, 8'd0);
    check("mid_rst_wrap",   wrap_count, 8'd0);
    check("mid_rst_sticky", err_sticky, 1'b0);
    flags_quiet("mid_rst");
    reset = 1'b0;

    // Randomized soak: mostly clean streams with occasional glitches
    v = 27;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(999, 0);
      reset     = (r < 4);
      enable    = !(r >= 4 && r < 20);
      clear_err = ($urandom_range(99, 0) < 4);
      v = (v + 1) % MOD;
      a = v;
      b = v;
      r = $urandom_range(299, 0);
      if (r < 3) begin
        a = $urandom_range(MOD - 1, 0);
      end else if (r < 6) begin
        b = $urandom_range(MOD - 1, 0);
      end else if (r < 9) begin
        v = (v + MOD - 1) % MOD;
        a = v;
        b = v;
      end
      drive(a, b);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_count_monitor
